// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave exposing NREGS registers of DATA_W bits to an SPI master.
//
// Ports:
//   theClock, theReset      system clock, synchronous active-high reset
//   MySPI_clk/_cs/_sdi      asynchronous SPI pins (SCK idles low, CS active low)
//   MySPI_sdo               MISO, MSB of the shift register during the data phase
//   Data_In                 read values, register k at [k*DATA_W +: DATA_W]
//   Data_Out                written register values, same packing
//   wr_strobe, rd_strobe    one-cycle per-register write / read-load pulses
//   busy                    high while a frame is in progress
//
// Frame: command byte {W, A[6:0]} then any number of DATA_W-bit words, address
// auto-incrementing with a 7-bit wrap.
module spi_reg_slave #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       NREGS     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    theClock,
    input  logic                    theReset,
    input  logic                    MySPI_clk,
    input  logic                    MySPI_cs,
    input  logic                    MySPI_sdi,
    output logic                    MySPI_sdo,
    input  logic [NREGS*DATA_W-1:0] Data_In,
    output logic [NREGS*DATA_W-1:0] Data_Out,
    output logic [NREGS-1:0]        wr_strobe,
    output logic [NREGS-1:0]        rd_strobe,
    output logic                    busy
);

    typedef enum logic [2:0] {S_Idle, S_Cmd, S_Load, S_Data, S_Commit} state_e;

    localparam logic [5:0] CmdBits  = 6'd8;
    localparam logic [5:0] DataBits = 6'(DATA_W);

    state_e                    state_q, state_d;
    logic                      sck_meta_q, sck_meta_d, sck_s_q, sck_s_d, sck_d_q, sck_d_d;
    logic                      cs_meta_q, cs_meta_d, cs_s_q, cs_s_d;
    logic [5:0]                bit_cnt_q, bit_cnt_d;
    logic [7:0]                cmd_q, cmd_d;
    logic [DATA_W-1:0]         shift_q, shift_d;
    logic [NREGS*DATA_W-1:0]   data_out_q, data_out_d;
    logic [NREGS-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic                      sdo_q, sdo_d;

    logic                      rise, fall;
    logic [NREGS-1:0]          sel;
    logic [DATA_W-1:0]         rd_word;

    assign rise = sck_s_q & ~sck_d_q;
    assign fall = ~sck_s_q & sck_d_q;

    // Decode the current address; an all-zero sel means out of range.
    always_comb begin
        sel     = '0;
        rd_word = '0;
        for (int k = 0; k < int'(NREGS); k++) begin
            if (cmd_q[6:0] == 7'(k)) begin
                sel[k]  = 1'b1;
                rd_word = Data_In[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        sck_meta_d = MySPI_clk;
        sck_s_d    = sck_meta_q;
        sck_d_d    = sck_s_q;
        cs_meta_d  = MySPI_cs;
        cs_s_d     = cs_meta_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        wr_d       = '0;
        rd_d       = '0;

        unique case (state_q)
            S_Idle: begin
                bit_cnt_d = '0;
                if (!cs_s_q) state_d = S_Cmd;
            end
            S_Cmd: begin
                if (rise) begin
                    cmd_d     = {cmd_q[6:0], MySPI_sdi};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else if (fall && bit_cnt_q == CmdBits) begin
                    state_d = S_Load;
                end
            end
            S_Load: begin
                shift_d   = (|sel) ? rd_word : '0;
                rd_d      = cmd_q[7] ? '0 : sel;
                bit_cnt_d = '0;
                state_d   = S_Data;
            end
            S_Data: begin
                if (rise) begin
                    shift_d   = {shift_q[DATA_W-2:0], MySPI_sdi};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else if (fall && bit_cnt_q == DataBits) begin
                    state_d = S_Commit;
                end
            end
            S_Commit: begin
                if (cmd_q[7]) begin
                    for (int k = 0; k < int'(NREGS); k++) begin
                        if (sel[k]) data_out_d[k*DATA_W +: DATA_W] = shift_q;
                    end
                    wr_d = sel;
                end
                cmd_d[6:0] = cmd_q[6:0] + 7'd1;
                state_d    = S_Load;
            end
            default: state_d = S_Idle;
        endcase

        // CS high aborts from any state; this cycle's commit or load still completes.
        if (cs_s_q) state_d = S_Idle;

        sdo_d = (state_d == S_Data) ? shift_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge theClock) begin
        if (theReset) begin
            state_q    <= S_Idle;
            sck_meta_q <= 1'b0;
            sck_s_q    <= 1'b0;
            sck_d_q    <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_s_q     <= 1'b1;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            shift_q    <= '0;
            data_out_q <= {NREGS{RESET_VAL}};
            wr_q       <= '0;
            rd_q       <= '0;
            sdo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_meta_q <= sck_meta_d;
            sck_s_q    <= sck_s_d;
            sck_d_q    <= sck_d_d;
            cs_meta_q  <= cs_meta_d;
            cs_s_q     <= cs_s_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            sdo_q      <= sdo_d;
        end
    end

    assign MySPI_sdo = sdo_q;
    assign Data_Out  = data_out_q;
    assign wr_strobe = wr_q;
    assign rd_strobe = rd_q;
    assign busy      = (state_q != S_Idle);

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a small instance (8-bit x 4, RESET_VAL 0xC3) and a
// wide instance (16-bit x 128) share the SPI pins; SCK runs at clk/10.
module tb_spi_reg_slave;

    logic           clk = 1'b0;
    logic           rst, sck, cs, sdi;
    logic           sdo_a, sdo_b, busy_a, busy_b;
    logic [31:0]    din_a, dout_a;
    logic [3:0]     wr_a, rd_a;
    logic [2047:0]  din_b, dout_b;
    logic [127:0]   wr_b, rd_b;

    int             checks = 0;
    int             passed = 0;
    int             wr_n = 0;
    int             rd_n = 0;
    logic [3:0]     wr_log [8];
    logic [3:0]     rd_log [8];
    logic [31:0]    rxa, rxb;

    always #5 clk = ~clk;

    spi_reg_slave #(.DATA_W(8), .NREGS(4), .RESET_VAL(8'hC3)) dut_a (
        .theClock(clk), .theReset(rst), .MySPI_clk(sck), .MySPI_cs(cs), .MySPI_sdi(sdi),
        .MySPI_sdo(sdo_a), .Data_In(din_a), .Data_Out(dout_a), .wr_strobe(wr_a),
        .rd_strobe(rd_a), .busy(busy_a)
    );

    spi_reg_slave #(.DATA_W(16), .NREGS(128)) dut_b (
        .theClock(clk), .theReset(rst), .MySPI_clk(sck), .MySPI_cs(cs), .MySPI_sdi(sdi),
        .MySPI_sdo(sdo_b), .Data_In(din_b), .Data_Out(dout_b), .wr_strobe(wr_b),
        .rd_strobe(rd_b), .busy(busy_b)
    );

    // Log every cycle with a strobe active on the small instance.
    always @(negedge clk) begin
        if (wr_a !== 4'b0) begin
            if (wr_n < 8) wr_log[wr_n] = wr_a;
            wr_n++;
        end
        if (rd_a !== 4'b0) begin
            if (rd_n < 8) rd_log[rd_n] = rd_a;
            rd_n++;
        end
    end

    task automatic spi_bit(input logic b, output logic ra, output logic rb);
        sdi = b;
        repeat (5) @(posedge clk);
        #1 sck = 1'b1;
        ra = sdo_a;
        rb = sdo_b;
        repeat (5) @(posedge clk);
        #1 sck = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                         output logic [31:0] ra_w, output logic [31:0] rb_w);
        logic ra, rb;
        ra_w = '0;
        rb_w = '0;
        cs = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], ra, rb);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(data[i], ra, rb);
            ra_w = {ra_w[30:0], ra};
            rb_w = {rb_w[30:0], rb};
        end
        @(posedge clk);
        #1 cs = 1'b1;
        sdi = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_n = 0;
        rd_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dout_a !== 32'hC3C3C3C3) $display("FAIL reset_dout got %h want C3C3C3C3", dout_a);
        else passed++;
        checks++;
        if (wr_a !== 4'b0 || rd_a !== 4'b0)
            $display("FAIL reset_strobes got wr=%b rd=%b want 0000/0000", wr_a, rd_a);
        else passed++;
        checks++;
        if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a);
        else passed++;
        checks++;
        if (sdo_a !== 1'b0) $display("FAIL reset_sdo got %b want 0", sdo_a);
        else passed++;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        clear_logs();
        frame(8'h81, 32'hA5, 8, rxa, rxb);
        checks++;
        if (dout_a !== 32'hC3C3A5C3) $display("FAIL write_dout got %h want C3C3A5C3", dout_a);
        else passed++;
        checks++;
        if (wr_n !== 1 || wr_log[0] !== 4'b0010)
            $display("FAIL write_strobe got n=%0d first=%b want n=1 first=0010", wr_n, wr_log[0]);
        else passed++;
        checks++;
        if (rd_n !== 0) $display("FAIL write_no_rd got %0d want 0", rd_n);
        else passed++;
        checks++;
        if (busy_a !== 1'b0) $display("FAIL write_busy_end got %b want 0", busy_a);
        else passed++;
    endtask

    task automatic test_single_read();
        clear_logs();
        frame(8'h02, 32'h00, 8, rxa, rxb);
        checks++;
        if (rxa !== 32'h3C) $display("FAIL read_miso got %h want 3c", rxa);
        else passed++;
        checks++;
        if (rd_n !== 1 || rd_log[0] !== 4'b0100)
            $display("FAIL read_strobe got n=%0d first=%b want n=1 first=0100", rd_n, rd_log[0]);
        else passed++;
        checks++;
        if (dout_a !== 32'hC3C3A5C3 || wr_n !== 0)
            $display("FAIL read_no_write got dout=%h wr_n=%0d want C3C3A5C3/0", dout_a, wr_n);
        else passed++;
    endtask

    task automatic test_burst_write();
        clear_logs();
        frame(8'h82, 32'h112233, 24, rxa, rxb);
        checks++;
        if (dout_a !== 32'h2211A5C3) $display("FAIL burst_dout got %h want 2211A5C3", dout_a);
        else passed++;
        checks++;
        if (wr_n !== 2 || wr_log[0] !== 4'b0100 || wr_log[1] !== 4'b1000)
            $display("FAIL burst_strobe got n=%0d seq=%b,%b want 2: 0100,1000",
                     wr_n, wr_log[0], wr_log[1]);
        else passed++;
    endtask

    task automatic test_abort();
        clear_logs();
        frame(8'h80, 32'h1F, 5, rxa, rxb);
        checks++;
        if (dout_a !== 32'h2211A5C3 || wr_n !== 0)
            $display("FAIL abort_no_write got dout=%h wr_n=%0d want 2211A5C3/0", dout_a, wr_n);
        else passed++;
        checks++;
        if (busy_a !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_a);
        else passed++;
        frame(8'h80, 32'h5A, 8, rxa, rxb);
        checks++;
        if (dout_a !== 32'h2211A55A) $display("FAIL abort_next got %h want 2211A55A", dout_a);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic ra, rb;
        logic [7:0] c;
        clear_logs();
        c = 8'h83;
        cs = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(c[i], ra, rb);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, ra, rb);
        checks++;
        if (busy_a !== 1'b1) $display("FAIL midreset_busy_before got %b want 1", busy_a);
        else passed++;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dout_a !== 32'hC3C3C3C3) $display("FAIL midreset_dout got %h want C3C3C3C3", dout_a);
        else passed++;
        checks++;
        if (busy_a !== 1'b0) $display("FAIL midreset_idle got %b want 0", busy_a);
        else passed++;
        rst = 1'b0;
        cs = 1'b1;
        sdi = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        clear_logs();
        frame(8'h83, 32'h77, 8, rxa, rxb);
        checks++;
        if (dout_a !== 32'h77C3C3C3 || wr_n !== 1 || wr_log[0] !== 4'b1000)
            $display("FAIL midreset_next got dout=%h n=%0d first=%b want 77C3C3C3/1/1000",
                     dout_a, wr_n, wr_log[0]);
        else passed++;
    endtask

    task automatic test_wide_wrap();
        frame(8'h7F, 32'hBEEF1234, 32, rxa, rxb);
        checks++;
        if (rxb !== 32'hBEEF1234) $display("FAIL wide_wrap_miso got %h want beef1234", rxb);
        else passed++;
    endtask

    initial begin
        din_a = {8'h99, 8'h3C, 8'h77, 8'hE1};
        din_b = '0;
        for (int k = 0; k < 128; k++) din_b[k*16 +: 16] = 16'(k * 257);
        din_b[127*16 +: 16] = 16'hBEEF;
        din_b[15:0]         = 16'h1234;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_abort();
        test_reset_mid();
        test_wide_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
